// File: rtl/px_fifo_apb_reader.sv
// APB3 completer draining the pixel capture FIFO: CTRL/STATUS/DATA/FRAME_LEN registers.
// Optional holding-register prefetch is enabled by defining PX_FIFO_APB_READER_PREFETCH_EN.
module px_fifo_apb_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [3:0]            PADDR,
    input  logic [31:0]           PWDATA,
    output logic [31:0]           PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic                  fifo_rden,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    input  logic                  fifo_empty,
    input  logic                  fifo_full,
    input  logic                  fifo_wren,
    input  logic                  capture_busy,
    output logic                  capture_start,
    output logic                  irq
);
    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_DATA   = 2'd2;
    localparam logic [1:0] A_FLEN   = 2'd3;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_POP, S_LATCH} state_t;

    state_t                 state;
    logic                   irq_en;
    logic                   ovf;
    logic                   frame_done;
    logic [CNT_WIDTH-1:0]   frame_len;
    logic [CNT_WIDTH-1:0]   words_read;
    logic [1:0]             sel;
    logic                   setup;
    logic                   wr_xfer;
    logic                   ctrl_wr;
    logic                   start;
    logic                   clr_ovf;
    logic                   ovf_set;
    logic                   data_rd;
    logic                   read_done;
    logic                   empty_flag;
    logic [31:0]            rd_word;
    logic                   unused_bits;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (c == {CNT_WIDTH{1'b1}}) ? c : c + CNT_ONE;
    endfunction

    function automatic logic [31:0] zext_data(input logic [DATA_WIDTH-1:0] d);
        logic [31:0] r;
        r = '0;
        r[DATA_WIDTH-1:0] = d;
        return r;
    endfunction

    function automatic logic [31:0] zext_cnt(input logic [CNT_WIDTH-1:0] c);
        logic [31:0] r;
        r = '0;
        r[CNT_WIDTH-1:0] = c;
        return r;
    endfunction

    assign sel         = PADDR[3:2];
    assign setup       = PSEL & ~PENABLE & (state == S_IDLE);
    assign wr_xfer     = setup & PWRITE;
    assign ctrl_wr     = wr_xfer & (sel == A_CTRL);
    assign start       = ctrl_wr & PWDATA[0];
    assign clr_ovf     = ctrl_wr & PWDATA[1];
    assign ovf_set     = fifo_wren & fifo_full;
    assign data_rd     = setup & ~PWRITE & (sel == A_DATA);
    assign irq         = irq_en & (frame_done | ovf);
    assign unused_bits = ^{PADDR[1:0], PWDATA};

`ifdef PX_FIFO_APB_READER_PREFETCH_EN
    logic                  hold_valid;
    logic                  in_flight;
    logic                  take_inflight;
    logic [DATA_WIDTH-1:0] hold;

    // Auto-pop keeps hold filled; a word arriving for a waiting read bypasses hold.
    assign fifo_rden     = ~reset & ~hold_valid & ~in_flight & ~fifo_empty & ~start;
    assign take_inflight = in_flight & ((state == S_POP) | (data_rd & ~hold_valid));
    assign empty_flag    = ~hold_valid & fifo_empty;
    assign read_done     = (state == S_POP) | (data_rd & (hold_valid | in_flight));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_valid <= 1'b0;
            in_flight  <= 1'b0;
        end else begin
            in_flight <= fifo_rden;
            if (start)
                hold_valid <= 1'b0;
            else if (in_flight & ~take_inflight)
                hold_valid <= 1'b1;
            else if (data_rd & hold_valid)
                hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (in_flight)
            hold <= fifo_rdata;
    end
`else
    assign fifo_rden  = ~reset & data_rd & ~fifo_empty;
    assign empty_flag = fifo_empty;
    assign read_done  = (state == S_POP);
`endif

    always_comb begin
        rd_word = '0;
        case (sel)
            A_CTRL:   rd_word[2] = irq_en;
            A_STATUS: begin
                rd_word[16 +: CNT_WIDTH] = words_read;
                rd_word[4:0] = {frame_done, capture_busy, ovf, fifo_full, empty_flag};
            end
            A_FLEN:   rd_word = zext_cnt(frame_len);
            default:  rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            PRDATA        <= '0;
            PREADY        <= 1'b0;
            PSLVERR       <= 1'b0;
            capture_start <= 1'b0;
            irq_en        <= 1'b0;
            ovf           <= 1'b0;
            frame_done    <= 1'b0;
            frame_len     <= '0;
            words_read    <= '0;
        end else begin
            PREADY        <= 1'b0;
            PSLVERR       <= 1'b0;
            capture_start <= start;
            ovf           <= ovf_set | (ovf & ~clr_ovf);

            if (ctrl_wr)
                irq_en <= PWDATA[2];
            if (wr_xfer && sel == A_FLEN)
                frame_len <= PWDATA[CNT_WIDTH-1:0];

            if (start)
                words_read <= '0;
            else if (read_done)
                words_read <= sat_inc(words_read);

            if (start)
                frame_done <= 1'b0;
            else if (frame_len != '0 && words_read == frame_len)
                frame_done <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (data_rd) begin
`ifdef PX_FIFO_APB_READER_PREFETCH_EN
                        if (hold_valid | in_flight) begin
                            PRDATA <= hold_valid ? zext_data(hold) : zext_data(fifo_rdata);
                            PREADY <= 1'b1;
                        end else if (fifo_rden) begin
                            state <= S_POP;
                        end else begin
                            PRDATA  <= '0;
                            PREADY  <= 1'b1;
                            PSLVERR <= 1'b1;
                        end
`else
                        if (!fifo_empty) begin
                            state <= S_POP;
                        end else begin
                            PRDATA  <= '0;
                            PREADY  <= 1'b1;
                            PSLVERR <= 1'b1;
                        end
`endif
                    end else if (setup) begin
                        PRDATA  <= PWRITE ? 32'd0 : rd_word;
                        PREADY  <= 1'b1;
                        PSLVERR <= PWRITE & ((sel == A_STATUS) | (sel == A_DATA));
                    end
                end
                S_POP: begin
                    PRDATA <= zext_data(fifo_rdata);
                    PREADY <= 1'b1;
                    state  <= S_LATCH;
                end
                S_LATCH: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
